// File: rtl/psec_spi_regbank.sv
// SPI slave for the PSEC configuration bank: decodes {rw, addr} command frames into a register
// file with burst auto-increment, reg0 instruction pulses, clock-enable control and framing status.
module psec_spi_regbank #(
  parameter int                         ADDR_W   = 7,
  parameter int                         DATA_W   = 8,
  parameter int                         NUM_REGS = 16,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
  parameter bit                         AUTO_INC = 1'b1
) (
  input  logic                         spi_clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         pico,
  input  logic                         trigger_in,
  output logic                         poci_spi,
  output logic [ADDR_W-1:0]            addr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         inst_rst,
  output logic                         inst_readout,
  output logic                         inst_start,
  output logic                         clk_enable,
  output logic                         frame_err
);

  localparam int CMD_W = 1 + ADDR_W;
  localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int SR_W  = MAX_W - 1;
  localparam int CNT_W = $clog2(MAX_W);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SR_W-1:0]     in_sr;
  logic [DATA_W-1:0]   rd_sr;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [CMD_W-1:0]    cmd_word;
  logic [DATA_W-1:0]   wr_word;
  logic [ADDR_W-1:0]   addr_cmd;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_word;
  logic                cmd_last;
  logic                data_last;
  logic                rd_load;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (!AUTO_INC) return a;
    if (int'(a) == NUM_REGS - 1) return '0;
    return a + 1'b1;
  endfunction

  // The word being completed is the shift history plus the bit on pico this edge.
  assign cmd_word  = {in_sr[CMD_W-2:0], pico};
  assign wr_word   = {in_sr[DATA_W-2:0], pico};
  assign addr_cmd  = cmd_word[ADDR_W-1:0];
  assign addr_inc  = next_addr(addr);
  assign cmd_last  = (bit_cnt == CNT_W'(CMD_W - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
  assign ld_addr   = (state == CMD) ? addr_cmd : addr_inc;
  assign rd_load   = ((state == CMD) && cmd_last && !cmd_word[CMD_W-1]) ||
                     ((state == RDATA) && data_last);
  assign poci_spi  = (state == RDATA) & rd_sr[DATA_W-1];

  // reg0 reads back as status, MSB aligned; unimplemented addresses read as zero.
  always_comb begin
    ld_word = '0;
    if (ld_addr == '0) begin
      ld_word[DATA_W-1] = clk_enable;
      ld_word[DATA_W-2] = frame_err;
    end else if (in_range(ld_addr)) begin
      ld_word = regs[ld_addr[IDX_W-1:0]];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  always_ff @(posedge spi_clk) begin
    in_sr <= {in_sr[SR_W-2:0], pico};
    if (rd_load) begin
      rd_sr <= ld_word;
    end else if (state == RDATA) begin
      rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
    end

    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      addr         <= '0;
      wr_strobe    <= '0;
      inst_rst     <= 1'b0;
      inst_readout <= 1'b0;
      inst_start   <= 1'b0;
      clk_enable   <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
    end else begin
      wr_strobe    <= '0;
      inst_rst     <= 1'b0;
      inst_readout <= 1'b0;
      inst_start   <= 1'b0;

      // A stop request beats a start issued in the same cycle.
      if (trigger_in || inst_rst) clk_enable <= 1'b0;
      else if (inst_start)        clk_enable <= 1'b1;

      if (cs) begin
        if (state != IDLE && bit_cnt != '0) frame_err <= 1'b1;
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: begin
            if (cmd_last) begin
              bit_cnt <= '0;
              addr    <= addr_cmd;
              state   <= cmd_word[CMD_W-1] ? WDATA : RDATA;
              if (!cmd_word[CMD_W-1] && addr_cmd == '0) frame_err <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          WDATA: begin
            if (data_last) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              if (in_range(addr)) begin
                wr_strobe <= {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
                if (addr == '0) begin
                  inst_rst     <= (wr_word == DATA_W'(1));
                  inst_readout <= (wr_word == DATA_W'(2));
                  inst_start   <= (wr_word == DATA_W'(3));
                end else begin
                  regs[addr[IDX_W-1:0]] <= wr_word;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RDATA: begin
            if (data_last) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              if (addr_inc == '0) frame_err <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psec_spi_regbank.sv
// Bench for psec_spi_regbank: directed frames followed by random bursts/aborts, all scored
// against a transaction-level register/status model.
`timescale 1ns/1ps
module tb_psec_spi_regbank;

  localparam logic [127:0] RST_IMG = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;

  logic         spi_clk = 1'b0;
  logic         rst, cs, pico, trigger_in;
  logic         poci_spi;
  logic [6:0]   addr;
  logic [127:0] reg_q;
  logic [15:0]  wr_strobe;
  logic         inst_rst, inst_readout, inst_start, clk_enable, frame_err;

  psec_spi_regbank #(
    .ADDR_W(7), .DATA_W(8), .NUM_REGS(16), .RST_VAL(RST_IMG), .AUTO_INC(1'b1)
  ) dut (
    .spi_clk(spi_clk), .rst(rst), .cs(cs), .pico(pico), .trigger_in(trigger_in),
    .poci_spi(poci_spi), .addr(addr), .reg_q(reg_q), .wr_strobe(wr_strobe),
    .inst_rst(inst_rst), .inst_readout(inst_readout), .inst_start(inst_start),
    .clk_enable(clk_enable), .frame_err(frame_err)
  );

  always #5 spi_clk = ~spi_clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m_regs [16];
  logic       m_fe, m_ce;
  logic [6:0] m_addr;
  int         exp_start = 0, exp_rst = 0, exp_rdo = 0;
  int         n_start = 0, n_rst = 0, n_rdo = 0;
  int         cyc = 0;
  int         stb_idx[$], stb_cyc[$], exp_stb[$];
  logic [7:0] wbuf[$], rbuf[$];
  bit         trig_flag = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] m_inc(input logic [6:0] a);
    return (a == 7'd15) ? 7'd0 : a + 7'd1;
  endfunction

  function automatic logic [127:0] m_image();
    logic [127:0] img;
    for (int n = 0; n < 16; n++) img[n*8 +: 8] = m_regs[n];
    return img;
  endfunction

  task automatic m_reset();
    logic [127:0] img;
    img = RST_IMG;
    for (int n = 0; n < 16; n++) m_regs[n] = img[n*8 +: 8];
    m_fe = 1'b0; m_ce = 1'b0; m_addr = 7'd0;
  endtask

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'd0) begin
      if (d == 8'd1) begin exp_rst++; m_ce = 1'b0; end
      else if (d == 8'd2) exp_rdo++;
      else if (d == 8'd3) begin exp_start++; m_ce = 1'b1; end
    end else if (a < 7'd16) begin
      m_regs[a[3:0]] = d;
      exp_stb.push_back(int'(a));
    end
  endtask

  task automatic m_load(input logic [6:0] a, output logic [7:0] v);
    if (a == 7'd0) begin
      v = {m_ce, m_fe, 6'b0};
      m_fe = 1'b0;
    end else if (a < 7'd16) v = m_regs[a[3:0]];
    else v = 8'h00;
  endtask

  task automatic check_state();
    check("addr", 128'(addr), 128'(m_addr));
    check("reg_q", reg_q, m_image());
    check("frame_err", 128'(frame_err), 128'(m_fe));
    check("clk_enable", 128'(clk_enable), 128'(m_ce));
    check("poci_idle", 128'(poci_spi), 128'(0));
    check("strobe_count", 128'(stb_idx.size()), 128'(exp_stb.size()));
    for (int i = 0; i < exp_stb.size() && i < stb_idx.size(); i++)
      check("strobe_index", 128'(stb_idx[i]), 128'(exp_stb[i]));
    check("inst_start_cycles", 128'(n_start), 128'(exp_start));
    check("inst_rst_cycles", 128'(n_rst), 128'(exp_rst));
    check("inst_readout_cycles", 128'(n_rdo), 128'(exp_rdo));
  endtask

  // One SPI frame; abort_at < 0 runs it to completion, else cs rises after that many bits.
  task automatic run_frame(input bit rw, input logic [6:0] a0, input int nwords, input int abort_at);
    logic [7:0] cmd, wsh, rsh, v;
    logic [6:0] a;
    int total, stop, done;
    cmd   = {rw, a0};
    total = 8 + 8 * nwords;
    stop  = (abort_at < 0) ? total : abort_at;
    stb_idx.delete(); stb_cyc.delete(); exp_stb.delete(); rbuf.delete();
    wsh = 8'h00; rsh = 8'h00;
    cs = 1'b0;
    @(negedge spi_clk);
    for (int b = 0; b < stop; b++) begin
      if (b < 8) begin
        pico = cmd[7];
        cmd  = {cmd[6:0], 1'b0};
      end else begin
        if ((b - 8) % 8 == 0) wsh = wbuf[(b - 8) / 8];
        if (rw) begin
          pico = wsh[7];
          wsh  = {wsh[6:0], 1'b0};
        end else begin
          rsh  = {rsh[6:0], poci_spi};
          pico = 1'($urandom);
          if ((b - 8) % 8 == 7) rbuf.push_back(rsh);
        end
      end
      @(negedge spi_clk);
    end
    cs = 1'b1; pico = 1'b0; trigger_in = trig_flag;
    @(negedge spi_clk);
    trigger_in = 1'b0;
    repeat (2) @(negedge spi_clk);

    done = (stop >= 8) ? (stop - 8) / 8 : -1;
    if (done >= 0) begin
      a = a0;
      if (rw) begin
        for (int w = 0; w < done; w++) begin
          m_write(a, wbuf[w]);
          a = m_inc(a);
        end
      end else begin
        for (int w = 0; w <= done; w++) begin
          m_load(a, v);
          if (w < done) begin
            check("read_word", 128'(rbuf[w]), 128'(v));
            a = m_inc(a);
          end
        end
      end
      m_addr = a;
    end
    if (stop % 8 != 0) m_fe = 1'b1;
    if (trig_flag) m_ce = 1'b0;
    check_state();
  endtask

  initial begin
    logic [15:0] s;
    forever begin
      @(negedge spi_clk);
      cyc++;
      s = wr_strobe >> 1;
      for (int i = 1; i < 16; i++) begin
        if (s[0]) begin
          stb_idx.push_back(i);
          stb_cyc.push_back(cyc);
        end
        s = s >> 1;
      end
      if (inst_start)   n_start++;
      if (inst_rst)     n_rst++;
      if (inst_readout) n_rdo++;
    end
  end

  initial begin
    int         nw, ab;
    bit         rw;
    logic [6:0] a0;
    logic [7:0] sh;

    rst = 1'b1; cs = 1'b1; pico = 1'b0; trigger_in = 1'b0;
    m_reset();
    repeat (3) @(negedge spi_clk);
    rst = 1'b0;
    @(negedge spi_clk);
    check("rst_reg_q", reg_q, RST_IMG);
    check("rst_addr", 128'(addr), 128'(0));
    check("rst_poci", 128'(poci_spi), 128'(0));
    check("rst_wr_strobe", 128'(wr_strobe), 128'(0));
    check("rst_inst", 128'({inst_rst, inst_readout, inst_start}), 128'(0));
    check("rst_clk_enable", 128'(clk_enable), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));

    // Burst read straight after reset returns reset values of reg1 and reg2.
    wbuf.delete();
    run_frame(1'b0, 7'd1, 2, -1);
    check("read_reset_reg1", 128'(rbuf[0]), 128'(8'h1E));
    check("read_reset_reg2", 128'(rbuf[1]), 128'(8'h2D));

    wbuf = '{8'hA5, 8'h3C};
    run_frame(1'b1, 7'd1, 2, -1);
    check("burst_reg1", 128'(reg_q[15:8]), 128'(8'hA5));
    check("burst_reg2", 128'(reg_q[23:16]), 128'(8'h3C));
    check("burst_addr_end", 128'(addr), 128'(3));
    check("burst_strobe_gap", 128'((stb_cyc.size() == 2) ? stb_cyc[1] - stb_cyc[0] : -1), 128'(8));

    wbuf = '{8'h77, 8'h02};
    run_frame(1'b1, 7'd15, 2, -1);
    check("wrap_reg15", 128'(reg_q[127:120]), 128'(8'h77));
    check("wrap_reg0_not_stored", 128'(reg_q[7:0]), 128'(8'h0F));
    check("wrap_readout_pulse", 128'(n_rdo), 128'(1));
    check("wrap_addr_end", 128'(addr), 128'(1));

    wbuf = '{8'h03};
    run_frame(1'b1, 7'd0, 1, -1);
    check("start_clk_enable", 128'(clk_enable), 128'(1));
    check("start_pulse_cycles", 128'(n_start), 128'(1));
    trig_flag = 1'b1;
    run_frame(1'b1, 7'd0, 1, -1);
    trig_flag = 1'b0;
    check("trigger_wins", 128'(clk_enable), 128'(0));
    check("start2_pulse_cycles", 128'(n_start), 128'(2));

    wbuf = '{8'h99};
    run_frame(1'b1, 7'd5, 1, 12);
    check("abort_reg5_kept", 128'(reg_q[47:40]), 128'(8'h5A));
    check("abort_frame_err", 128'(frame_err), 128'(1));
    wbuf.delete();
    run_frame(1'b0, 7'd0, 1, -1);
    check("status_read", 128'(rbuf[0]), 128'(8'h40));
    check("status_clears_err", 128'(frame_err), 128'(0));

    wbuf = '{8'h55};
    run_frame(1'b1, 7'h40, 1, -1);
    check("oor_no_strobe", 128'(stb_idx.size()), 128'(0));
    wbuf.delete();
    run_frame(1'b0, 7'h40, 1, -1);
    check("oor_read_zero", 128'(rbuf[0]), 128'(0));

    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 4);
      rw = 1'($urandom_range(0, 1));
      a0 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
      wbuf.delete();
      for (int w = 0; w < nw; w++)
        wbuf.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8 + 8 * nw - 1)) : -1;
      run_frame(rw, a0, nw, ab);
    end

    // Reset in the middle of a write word drops the frame without flagging an error.
    wbuf = '{8'h03};
    run_frame(1'b1, 7'd0, 1, -1);
    stb_idx.delete(); exp_stb.delete();
    cs = 1'b0;
    @(negedge spi_clk);
    sh = 8'h83;
    for (int b = 0; b < 11; b++) begin
      pico = sh[7];
      sh = {sh[6:0], 1'b1};
      @(negedge spi_clk);
    end
    rst = 1'b1;
    @(negedge spi_clk);
    rst = 1'b0; cs = 1'b1;
    repeat (2) @(negedge spi_clk);
    m_reset();
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
